// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: PC, single-outstanding arbiter reads, instruction FIFO to decode.
// Optional macro HS32_FETCH_BYPASS_EN forwards an ack straight to decode when the FIFO is empty.
module hs32_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newpc,
  input  logic        flush,
  output logic [31:0] addr,
  output logic        reqm,
  input  logic [31:0] dtr,
  input  logic        ackm,
  output logic [31:0] instd,
  output logic [31:0] ipc,
  output logic        ivalid,
  input  logic        iready,
  output logic [1:0]  dbg_state
);
  // Handshakes: reqm/addr are held from issue until the cycle ackm=1, which ends the request;
  // decode takes the head word on any edge where ivalid & iready & !flush.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        mem_d  [FIFO_DEPTH];
  logic [31:0]        mem_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               fifo_empty;
  logic               ack_take;
  logic               push;
  logic               pop;
  logic               space;

  assign fifo_empty = (count == '0);
  // Only an ack for a live request carries a word; dropped or flushed acks are discarded.
  assign ack_take   = (state == REQ) && ackm && !flush;
  assign pop        = !fifo_empty && iready && !flush;

`ifdef HS32_FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = ack_take && fifo_empty;
  assign push       = ack_take && !(bypass_hit && iready);
  assign ivalid     = !fifo_empty || bypass_hit;
  assign instd      = bypass_hit ? dtr : mem_d[rd_ptr];
  assign ipc        = bypass_hit ? pc  : mem_pc[rd_ptr];
`else
  assign push       = ack_take;
  assign ivalid     = !fifo_empty;
  assign instd      = mem_d[rd_ptr];
  assign ipc        = mem_pc[rd_ptr];
`endif

  // After this edge nothing is in flight, so count_next alone decides whether a new word fits.
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign space      = (count_next < CNT_W'(FIFO_DEPTH));
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      reqm  <= 1'b0;
      addr  <= '0;
    end else begin
      if (flush) pc <= newpc & ~32'h3;
      case (state)
        IDLE: begin
          if (!flush && space) begin
            reqm  <= 1'b1;
            addr  <= pc;
            state <= REQ;
          end
        end
        REQ: begin
          if (ackm) begin
            if (flush) begin
              reqm  <= 1'b0;
              state <= IDLE;
            end else begin
              pc <= pc + 32'd4;
              if (space) begin
                addr <= pc + 32'd4;
              end else begin
                reqm  <= 1'b0;
                state <= IDLE;
              end
            end
          end else if (flush) begin
            // The arbiter cannot abort, so keep the request up and discard its data later.
            state <= DROP;
          end
        end
        DROP: begin
          if (ackm) begin
            reqm  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          reqm  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i]  <= '0;
        mem_pc[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr]  <= dtr;
        mem_pc[wr_ptr] <= pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule
